// File: rtl/neuron_mac_accum.sv
// Neuron front end: pipelined multiply-accumulate of one input vector plus bias,
// saturated to 2*dataWidth and presented with a one-cycle valid pulse.
module neuron_mac_accum #(
  parameter int unsigned dataWidth = 16,
  parameter int unsigned numWeight = 784,
  localparam int unsigned cntWidth = $clog2(numWeight) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [dataWidth-1:0]     in_data,
  input  logic [dataWidth-1:0]     in_weight,
  input  logic [2*dataWidth-1:0]   bias,
  output logic [2*dataWidth-1:0]   sum_out,
  output logic                     sum_valid
);

  localparam int unsigned SW = 2 * dataWidth;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    WAIT = 2'd1,
    BIAS = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [cntWidth-1:0]   cnt;
  logic [SW-1:0]         acc;
  logic [SW-1:0]         mul_r;
  logic                  mul_v;
  logic                  mul_last;
  logic                  accept;
  logic                  last_pos;
  logic [SW-1:0]         data_ext;
  logic [SW-1:0]         weight_ext;
  logic [SW-1:0]         product;

  // Two's complement add that clamps instead of wrapping; not sticky.
  function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] s;
    s = a + b;
    if ((a[SW-1] == b[SW-1]) && (s[SW-1] != a[SW-1]))
      s = a[SW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
    return s;
  endfunction

  assign in_ready   = (state_q == ACC);
  assign accept     = in_valid & in_ready;
  assign last_pos   = (cnt == cntWidth'(numWeight - 1));

  // Sign-extend first so the low SW bits of the unsigned product are the signed product.
  assign data_ext   = {{dataWidth{in_data[dataWidth-1]}}, in_data};
  assign weight_ext = {{dataWidth{in_weight[dataWidth-1]}}, in_weight};
  assign product    = data_ext * weight_ext;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:     if (accept && last_pos) state_d = WAIT;
      WAIT:    if (mul_last) state_d = BIAS;
      BIAS:    state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  // Stage 1: multiply and track position within the vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      mul_r    <= '0;
      mul_v    <= 1'b0;
      mul_last <= 1'b0;
    end else begin
      mul_v <= accept;
      if (accept) begin
        mul_r    <= product;
        mul_last <= last_pos;
        cnt      <= last_pos ? '0 : cnt + cntWidth'(1);
      end
    end
  end

  // Stage 2: accumulate; the bias cycle publishes the result and clears the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (state_q == BIAS) begin
        sum_out   <= sat_add(acc, bias);
        sum_valid <= 1'b1;
        acc       <= '0;
      end else if (mul_v) begin
        acc <= sat_add(acc, mul_r);
      end
    end
  end

endmodule
